fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register of the pipelined SIMPLE processor.
- Holds the PC and drives the synchronous instruction memory.
- Latches the fetched word and slices it into op1/op2/op3/opcond fields for the downstream decoder (control_unit).
- Handles run gating, load-use stall, taken-branch redirect/flush and halt.

---
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined SIMPLE core.
// Optional fetch statistics counters are built when FETCH_STAT_EN is defined.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP_INST = 16'hC0E0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic            id_valid,
  output logic [15:0]     id_inst,
  output logic [PC_W-1:0] id_pc1,
  output logic [1:0]      op1,
  output logic [2:0]      op2,
  output logic [3:0]      op3,
  output logic [2:0]      opcond,
  output logic            halted
`ifdef FETCH_STAT_EN
  ,
  output logic [15:0]     stat_issued,
  output logic [15:0]     stat_bubbles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            fetch_pending_q, fetch_pending_d;
  logic            id_valid_q, id_valid_d;
  logic [15:0]     id_inst_q, id_inst_d;
  logic [PC_W-1:0] id_pc1_q, id_pc1_d;
  logic            halted_q, halted_d;

  assign pc_inc = pc_q + PC_ONE;

  // The memory always returns the word at pc when fetch_pending_q is set; a
  // cleared flag means the word in flight came from a stale address.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fetch_pending_d = fetch_pending_q;
    id_valid_d      = id_valid_q;
    id_inst_d       = id_inst_q;
    id_pc1_d        = id_pc1_q;
    halted_d        = halted_q;
    imem_addr       = pc_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d         = S_RUN;
          fetch_pending_d = 1'b1;
        end
      end
      S_RUN: begin
        if (branch_taken) begin
          imem_addr       = branch_target;
          pc_d            = branch_target;
          fetch_pending_d = 1'b0;
          id_valid_d      = 1'b0;
          id_inst_d       = NOP_INST;
        end else if (halt) begin
          state_d         = S_HALT;
          halted_d        = 1'b1;
          fetch_pending_d = 1'b0;
          id_valid_d      = 1'b0;
          id_inst_d       = NOP_INST;
        end else if (!run) begin
          state_d         = S_IDLE;
          fetch_pending_d = 1'b0;
          id_valid_d      = 1'b0;
          id_inst_d       = NOP_INST;
        end else if (stall) begin
          imem_addr = pc_q;
        end else if (!fetch_pending_q) begin
          // Squash cycle: re-present pc so the next word is the right one.
          fetch_pending_d = 1'b1;
          id_valid_d      = 1'b0;
          id_inst_d       = NOP_INST;
        end else begin
          imem_addr  = pc_inc;
          pc_d       = pc_inc;
          id_valid_d = 1'b1;
          id_inst_d  = imem_rdata;
          id_pc1_d   = pc_inc;
        end
      end
      S_HALT: begin
        imem_addr = pc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      fetch_pending_q <= 1'b0;
      id_valid_q      <= 1'b0;
      id_inst_q       <= NOP_INST;
      id_pc1_q        <= '0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fetch_pending_q <= fetch_pending_d;
      id_valid_q      <= id_valid_d;
      id_inst_q       <= id_inst_d;
      id_pc1_q        <= id_pc1_d;
      halted_q        <= halted_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_inst  = id_inst_q;
  assign id_pc1   = id_pc1_q;
  assign halted   = halted_q;
  assign op1      = id_inst_q[15:14];
  assign op2      = id_inst_q[13:11];
  assign opcond   = id_inst_q[10:8];
  assign op3      = id_inst_q[7:4];

`ifdef FETCH_STAT_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_bubbles_q, stat_bubbles_d;
  logic        issue_evt, bubble_evt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Halt and run-stop bubbles are not counted; branch, stall and squash are.
  always_comb begin
    issue_evt      = (state_q == S_RUN) && id_valid_d;
    bubble_evt     = (state_q == S_RUN) &&
                     (branch_taken || (!halt && run && (stall || !fetch_pending_q)));
    stat_issued_d  = issue_evt  ? sat_inc(stat_issued_q)  : stat_issued_q;
    stat_bubbles_d = bubble_evt ? sat_inc(stat_bubbles_q) : stat_bubbles_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_issued_q  <= '0;
      stat_bubbles_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_bubbles_q <= stat_bubbles_d;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_bubbles = stat_bubbles_q;
`endif

endmodule
